// File: rtl/pc_mar_counter_if.sv
// Bus bundle between the sequencer and the PC/MAR pair: load/increment strobes in,
// address values and PC carry/terminal-count status out.
interface pc_mar_counter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   bus_in;
    logic               pc_load;
    logic               pc_inc;
    logic               mar_load;
    logic               mar_inc;
    logic [WIDTH-1:0]   pc_q;
    logic [WIDTH-1:0]   mar_q;
    logic               pc_tc;
    logic [WIDTH/4-1:0] nib_carry;
    logic               pc_wrap;

    modport master (
        output bus_in, pc_load, pc_inc, mar_load, mar_inc,
        input  pc_q, mar_q, pc_tc, nib_carry, pc_wrap
    );

    modport slave (
        input  bus_in, pc_load, pc_inc, mar_load, mar_inc,
        output pc_q, mar_q, pc_tc, nib_carry, pc_wrap
    );
endinterface

// File: rtl/pc_mar_counter.sv
// Program counter built as cascaded 4-bit synchronous counter stages, plus an
// independent memory address register; PC feeds mux A inputs, MAR feeds mux B inputs.
module pc_mar_counter #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    pc_mar_counter_if.slave    bus
);
    localparam int NIBS = WIDTH / 4;

    logic [WIDTH-1:0] pc_cnt_q,  pc_cnt_d;
    logic [WIDTH-1:0] mar_reg_q, mar_reg_d;
    logic             wrap_q,    wrap_d;
    logic [NIBS-1:0]  nib_en;
    logic [NIBS-1:0]  carry;
    logic [WIDTH-1:0] pc_plus1;

    // Ripple cascade: a stage counts only when every lower stage is at 0xF.
    always_comb begin
        nib_en   = '0;
        carry    = '0;
        pc_plus1 = pc_cnt_q;
        nib_en[0] = bus.pc_inc;
        carry[0]  = nib_en[0] & (&pc_cnt_q[3:0]);
        if (nib_en[0]) begin
            pc_plus1[3:0] = pc_cnt_q[3:0] + 4'd1;
        end
        for (int i = 1; i < NIBS; i++) begin
            nib_en[i] = carry[i-1];
            carry[i]  = nib_en[i] & (&pc_cnt_q[i*4 +: 4]);
            if (nib_en[i]) begin
                pc_plus1[i*4 +: 4] = pc_cnt_q[i*4 +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        pc_cnt_d  = pc_cnt_q;
        mar_reg_d = mar_reg_q;
        wrap_d    = 1'b0;
        if (bus.pc_load) begin
            pc_cnt_d = bus.bus_in;
        end else if (bus.pc_inc) begin
            pc_cnt_d = pc_plus1;
            wrap_d   = carry[NIBS-1];
        end
        if (bus.mar_load) begin
            mar_reg_d = bus.bus_in;
        end else if (bus.mar_inc) begin
            mar_reg_d = mar_reg_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_cnt_q  <= RST_VEC;
            mar_reg_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            pc_cnt_q  <= pc_cnt_d;
            mar_reg_q <= mar_reg_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.pc_q      = pc_cnt_q;
    assign bus.mar_q     = mar_reg_q;
    assign bus.nib_carry = carry;
    assign bus.pc_tc     = carry[NIBS-1];
    assign bus.pc_wrap   = wrap_q;
endmodule

// File: tb/tb_pc_mar_counter.sv
// Directed bench for pc_mar_counter: reset, cascade carries, wrap pulse,
// load priority, MAR independence and mid-count reset.
module tb_pc_mar_counter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pc_mar_counter_if #(.WIDTH(16)) bif ();

    pc_mar_counter #(.WIDTH(16), .RST_VEC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] b, input logic pl, input logic pi,
                         input logic ml, input logic mi);
        bif.bus_in   = b;
        bif.pc_load  = pl;
        bif.pc_inc   = pi;
        bif.mar_load = ml;
        bif.mar_inc  = mi;
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(16'h1234, 1'b1, 1'b1, 1'b1, 1'b1);

        // reset beats load/inc of both registers
        tick();
        rst = 1'b0;
        drive(16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pc",   {16'h0, bif.pc_q},  32'h0000);
        chk("rst_mar",  {16'h0, bif.mar_q}, 32'h0000);
        chk("rst_wrap", {31'h0, bif.pc_wrap}, 32'h0);

        // load 0x00FE then count through nibble carries
        tick();
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_00fe",   {16'h0, bif.pc_q}, 32'h00FE);
        chk("nc_00fe",   {28'h0, bif.nib_carry}, 32'h0);
        tick();
        chk("inc_00ff",  {16'h0, bif.pc_q}, 32'h00FF);
        chk("nc_00ff",   {28'h0, bif.nib_carry}, 32'h3);
        chk("tc_00ff",   {31'h0, bif.pc_tc}, 32'h0);
        tick();
        chk("inc_0100",  {16'h0, bif.pc_q}, 32'h0100);
        chk("nc_0100",   {28'h0, bif.nib_carry}, 32'h0);
        tick();
        chk("inc_0101",  {16'h0, bif.pc_q}, 32'h0101);

        // terminal count and wrap pulse
        drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ld_ffff",   {16'h0, bif.pc_q}, 32'hFFFF);
        chk("tc_noinc",  {31'h0, bif.pc_tc}, 32'h0);
        chk("nc_noinc",  {28'h0, bif.nib_carry}, 32'h0);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("tc_ffff",   {31'h0, bif.pc_tc}, 32'h1);
        chk("nc_ffff",   {28'h0, bif.nib_carry}, 32'hF);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc",   {16'h0, bif.pc_q}, 32'h0000);
        chk("wrap_hi",   {31'h0, bif.pc_wrap}, 32'h1);
        tick();
        chk("wrap_lo",   {31'h0, bif.pc_wrap}, 32'h0);

        // load wins over inc; no wrap when loading from all ones
        drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(16'h4000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("tc_ld_ungated", {31'h0, bif.pc_tc}, 32'h1);
        tick();
        drive(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ld_over_inc", {16'h0, bif.pc_q}, 32'h4000);
        chk("ld_no_wrap",  {31'h0, bif.pc_wrap}, 32'h0);

        // MAR load alongside PC count, then MAR increment
        tick();
        drive(16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mar_ld",   {16'h0, bif.mar_q}, 32'hABCD);
        chk("pc_0011",  {16'h0, bif.pc_q},  32'h0011);
        tick();
        drive(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mar_inc",  {16'h0, bif.mar_q}, 32'hABCE);
        chk("pc_hold",  {16'h0, bif.pc_q},  32'h0011);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mar_ld_over_inc", {16'h0, bif.mar_q}, 32'hFFFF);
        tick();
        drive(16'h0FFE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mar_wrap", {16'h0, bif.mar_q}, 32'h0000);
        chk("mar_no_pcwrap", {31'h0, bif.pc_wrap}, 32'h0);

        // reset in the middle of a count
        tick();
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mid_0fff", {16'h0, bif.pc_q}, 32'h0FFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_pc",   {16'h0, bif.pc_q}, 32'h0000);
        chk("mid_rst_wrap", {31'h0, bif.pc_wrap}, 32'h0);
        tick();
        chk("resume_0001",  {16'h0, bif.pc_q}, 32'h0001);
        chk("resume_wrap",  {31'h0, bif.pc_wrap}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
